// File: rtl/bcd_serial_subtractor_if.sv
// Request/response bundle for the digit-serial BCD subtractor.
// The requester uses the master modport and the subtractor uses the slave modport.
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start_valid;
  logic                  start_ready;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  done_valid;
  logic                  done_ready;
  logic [4*DIGITS-1:0]   result;
  logic                  neg;
  logic                  invalid;

  modport master (
    output start_valid, A, B, done_ready,
    input  start_ready, done_valid, result, neg, invalid
  );

  modport slave (
    input  start_valid, A, B, done_ready,
    output start_ready, done_valid, result, neg, invalid
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD |A-B| with sign flag: one digit per clock, LSD first.
// When A < B, a second ten's-complement pass runs over the result register.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bcd_serial_subtractor_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DIGITS-1:0][3:0]  a_q, b_q, res_q;
  logic [IW-1:0]           idx;
  logic                    borrow, neg_q, inv_q;
  logic                    accept, last, bad;
  logic [3:0]              x, y, dig_r;
  logic [4:0]              d;
  logic                    dig_b;

  assign accept = bus.start_valid && (state == IDLE);
  assign last   = (idx == IW'(DIGITS - 1));

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a_q[i] > 4'd9 || b_q[i] > 4'd9) bad = 1'b1;
  end

  // Shared digit stage: SUB does a-b-borrow, NEG does 0-r-borrow.
  always_comb begin
    x     = (state == NEG) ? 4'd0 : a_q[idx];
    y     = (state == NEG) ? res_q[idx] : b_q[idx];
    d     = {1'b0, x} - {1'b0, y} - {4'd0, borrow};
    dig_b = d[4];
    dig_r = d[4] ? (d[3:0] + 4'd10) : d[3:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SUB;
      SUB: begin
        if (bad)       state_nxt = DONE;
        else if (last) state_nxt = dig_b ? NEG : DONE;
      end
      NEG:  if (last) state_nxt = DONE;
      DONE: if (bus.done_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.start_ready = (state == IDLE);
    bus.done_valid  = (state == DONE);
  end

  // Operand latch, in-place result digits, index and borrow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      neg_q  <= 1'b0;
      inv_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q    <= bus.A;
          b_q    <= bus.B;
          res_q  <= '0;
          idx    <= '0;
          borrow <= 1'b0;
          neg_q  <= 1'b0;
          inv_q  <= 1'b0;
        end
        SUB: begin
          if (bad) begin
            inv_q <= 1'b1;
          end else begin
            res_q[idx] <= dig_r;
            if (last) begin
              idx    <= '0;
              borrow <= 1'b0;
            end else begin
              idx    <= idx + IW'(1);
              borrow <= dig_b;
            end
          end
        end
        NEG: begin
          res_q[idx] <= dig_r;
          if (last) begin
            idx    <= '0;
            borrow <= 1'b0;
            neg_q  <= 1'b1;
          end else begin
            idx    <= idx + IW'(1);
            borrow <= dig_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = res_q;
  assign bus.neg     = neg_q;
  assign bus.invalid = inv_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed vector bench for bcd_serial_subtractor (DIGITS=4): result, sign,
// invalid flag, latency, backpressure and asynchronous reset abort.
module tb_bcd_serial_subtractor;
  logic clk, reset_n;
  int   checks = 0;
  int   errors = 0;

  bcd_serial_subtractor_if #(.DIGITS(4)) bus ();
  bcd_serial_subtractor #(.DIGITS(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a, b, r;
    logic        n, inv;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge while idle; returns with done_valid high (or timed out).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    bus.A = a; bus.B = b; bus.start_valid = 1'b1; bus.done_ready = 1'b0;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.A = ~a; bus.B = ~b;
    lat = 0;
    while (!bus.done_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack(input string name);
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    check({name, "_done_valid_drop"}, 32'(bus.done_valid), 32'd0);
    check({name, "_start_ready_rise"}, 32'(bus.start_ready), 32'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    check({name, "_start_ready"}, 32'(bus.start_ready), 32'd1);
    start_op(v.a, v.b, lat);
    check({name, "_latency"}, 32'(lat), 32'(v.lat));
    check({name, "_result"}, 32'(bus.result), 32'(v.r));
    check({name, "_neg"}, 32'(bus.neg), 32'(v.n));
    check({name, "_invalid"}, 32'(bus.invalid), 32'(v.inv));
    ack(name);
  endtask

  initial begin
    int lat;
    vecs[0] = '{16'h0482, 16'h0157, 16'h0325, 1'b0, 1'b0, 4};
    vecs[1] = '{16'h0157, 16'h0482, 16'h0325, 1'b1, 1'b0, 8};
    vecs[2] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 4};
    vecs[3] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4};
    vecs[4] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8};
    vecs[5] = '{16'h00A3, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vecs[6] = '{16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 4};
    vecs[7] = '{16'h5000, 16'h9999, 16'h4999, 1'b1, 1'b0, 8};
    vecs[8] = '{16'h0009, 16'h00F0, 16'h0000, 1'b0, 1'b1, 1};

    bus.start_valid = 1'b0; bus.done_ready = 1'b0; bus.A = '0; bus.B = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    check("rst_invalid", 32'(bus.invalid), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held, start_ready low, start pulses ignored.
    start_op(16'h0482, 16'h0157, lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int c = 0; c < 5; c++) begin
      bus.start_valid = c[0];
      bus.A = 16'h0001; bus.B = 16'h0009;
      @(posedge clk); #1;
      check($sformatf("bp_done_valid_%0d", c), 32'(bus.done_valid), 32'd1);
      check($sformatf("bp_result_%0d", c), 32'(bus.result), 32'h0325);
      check($sformatf("bp_neg_%0d", c), 32'(bus.neg), 32'd0);
      check($sformatf("bp_start_ready_%0d", c), 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    ack("bp");
    run_vec("after_bp", vecs[1]);

    // Asynchronous reset while digit 2 is in flight.
    bus.A = 16'h0482; bus.B = 16'h0157; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_partial_result", 32'(bus.result), 32'h0025);
    reset_n = 1'b0;
    #1;
    check("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("mid_rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_neg", 32'(bus.neg), 32'd0);
    check("mid_rst_invalid", 32'(bus.invalid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after_rst", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
